// File: rtl/aurora_clk_pkg.sv
// Shared types and width helpers for the Aurora MMCM supervisor.
// Imported by the supervisor top and its interface users.
package aurora_clk_pkg;

  typedef enum logic [2:0] {
    WAIT_SRC  = 3'd0,
    HOLD_RST  = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } sup_state_e;

  // Bits needed to hold values 0..n-1.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aurora_mmcm_supervisor_if.sv
// Control/status bundle between the clocking supervisor and its user.
// slave = supervisor side, master = system side.
interface aurora_mmcm_supervisor_if #(
  parameter int N_CLK  = 1,
  parameter int LOSS_W = 16
);

  logic [N_CLK-1:0]  CLK_LOCKED;
  logic              MMCM_LOCKED;
  logic              RETRY_REQ;
  logic              CLEAR_COUNTS;
  logic              TX_CLK_CLR;
  logic              MMCM_RESET;
  logic              CLK_READY;
  logic              FAULT;
  logic [2:0]        STATE;
  logic [7:0]        RETRY_COUNT;
  logic [LOSS_W-1:0] LOCK_LOSS_COUNT;

  modport master (
    output CLK_LOCKED,
    output MMCM_LOCKED,
    output RETRY_REQ,
    output CLEAR_COUNTS,
    input  TX_CLK_CLR,
    input  MMCM_RESET,
    input  CLK_READY,
    input  FAULT,
    input  STATE,
    input  RETRY_COUNT,
    input  LOCK_LOSS_COUNT
  );

  modport slave (
    input  CLK_LOCKED,
    input  MMCM_LOCKED,
    input  RETRY_REQ,
    input  CLEAR_COUNTS,
    output TX_CLK_CLR,
    output MMCM_RESET,
    output CLK_READY,
    output FAULT,
    output STATE,
    output RETRY_COUNT,
    output LOCK_LOSS_COUNT
  );

endinterface

// File: rtl/aurora_lock_sync.sv
// N-bit two-flop synchroniser for asynchronous lock/ready inputs.
// Both stages carry ASYNC_REG so placement keeps them adjacent.
module aurora_lock_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] s1_q;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/aurora_mmcm_supervisor.sv
// Reset/lock sequencer for the Aurora clocking MMCM on INIT_CLK.
// One FSM, one shared down-counter for reset/timeout/stable windows.
module aurora_mmcm_supervisor
  import aurora_clk_pkg::*;
#(
  parameter int N_CLK         = 1,
  parameter int RST_CYCLES    = 128,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int LOSS_W        = 16
) (
  input logic INIT_CLK,
  input logic INIT_RESET_N,
  aurora_mmcm_supervisor_if.slave sup
);

  localparam int CW = max3(
    cw(RST_CYCLES),
    cw(LOCK_TIMEOUT),
    cw(STABLE_CYCLES)
  );

  localparam int STB_N =
    (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;

  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LOAD = CW'(STB_N);
  localparam logic [7:0]    MAX_ATT  = 8'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  logic [N_CLK-1:0] clk_lk_s;
  logic             mmcm_lk_s;
  logic             src_ok;
  logic             lk;

  aurora_lock_sync #(
    .W(N_CLK)
  ) u_src_sync (
    .clk  (INIT_CLK),
    .rst_n(INIT_RESET_N),
    .d    (sup.CLK_LOCKED),
    .q    (clk_lk_s)
  );

  aurora_lock_sync #(
    .W(1)
  ) u_lk_sync (
    .clk  (INIT_CLK),
    .rst_n(INIT_RESET_N),
    .d    (sup.MMCM_LOCKED),
    .q    (mmcm_lk_s)
  );

  assign src_ok = &clk_lk_s;
  assign lk     = mmcm_lk_s;

  sup_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        att_q, att_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              clr_q, clr_d;
  logic              rst_q, rst_d;
  logic              rdy_q, rdy_d;
  logic              flt_q, flt_d;

  logic       fail;
  logic       lost;
  logic       src_drop;
  logic       cnt_fail;
  logic [7:0] att_nx;

  always_comb begin
    state_d  = state_q;
    fail     = 1'b0;
    lost     = 1'b0;
    att_nx   = att_q + 8'd1;
    unique case (state_q)
      WAIT_SRC: begin
        if (src_ok) state_d = HOLD_RST;
      end
      HOLD_RST: begin
        if (cnt_q == '0) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk) state_d = STABLE;
        else if (cnt_q == '0) fail = 1'b1;
      end
      STABLE: begin
        if (!lk) fail = 1'b1;
        else if (cnt_q == '0) state_d = RUN;
      end
      RUN: begin
        if (!lk) begin
          lost    = 1'b1;
          state_d = HOLD_RST;
        end
      end
      FAULT: begin
        if (sup.RETRY_REQ) state_d = WAIT_SRC;
      end
      default: state_d = WAIT_SRC;
    endcase

    if (fail) begin
      state_d = (att_nx == MAX_ATT) ? FAULT : HOLD_RST;
    end

    // Source loss overrides any lock outcome decided above.
    src_drop = !src_ok && (state_q != FAULT);
    if (src_drop) state_d = WAIT_SRC;
    cnt_fail = fail && !src_drop;
  end

  always_comb begin
    att_d = att_q;
    if (state_q == RUN) att_d = '0;
    if (cnt_fail) att_d = att_nx;
    if (state_q == FAULT && sup.RETRY_REQ) att_d = '0;

    rcnt_d = rcnt_q;
    if (sup.CLEAR_COUNTS) rcnt_d = '0;
    else if (cnt_fail && rcnt_q != 8'hff)
      rcnt_d = rcnt_q + 8'd1;

    loss_d = loss_q;
    if (sup.CLEAR_COUNTS) loss_d = '0;
    else if (lost && loss_q != LOSS_MAX)
      loss_d = loss_q + LOSS_W'(1);
  end

  always_comb begin
    cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    if (state_d != state_q) begin
      unique case (1'b1)
        (state_d == HOLD_RST):  cnt_d = RST_LOAD;
        (state_d == WAIT_LOCK): cnt_d = TMO_LOAD;
        (state_d == STABLE):    cnt_d = STB_LOAD;
        default:                cnt_d = '0;
      endcase
    end

    clr_d = (state_d == WAIT_SRC) || (state_d == FAULT);
    rst_d = (state_d == WAIT_SRC) ||
            (state_d == HOLD_RST) ||
            (state_d == FAULT);
    // Ready only once RUN has held for a full cycle.
    rdy_d = (state_q == RUN) && (state_d == RUN);
    flt_d = (state_d == FAULT);
  end

  always_ff @(posedge INIT_CLK) begin
    if (!INIT_RESET_N) begin
      state_q <= WAIT_SRC;
      cnt_q   <= '0;
      att_q   <= '0;
      rcnt_q  <= '0;
      loss_q  <= '0;
      clr_q   <= 1'b1;
      rst_q   <= 1'b1;
      rdy_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
      rcnt_q  <= rcnt_d;
      loss_q  <= loss_d;
      clr_q   <= clr_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      flt_q   <= flt_d;
    end
  end

  assign sup.TX_CLK_CLR      = clr_q;
  assign sup.MMCM_RESET      = rst_q;
  assign sup.CLK_READY       = rdy_q;
  assign sup.FAULT           = flt_q;
  assign sup.STATE           = state_q;
  assign sup.RETRY_COUNT     = rcnt_q;
  assign sup.LOCK_LOSS_COUNT = loss_q;

endmodule

// File: tb/tb_aurora_mmcm_supervisor.sv
// Directed bench for aurora_mmcm_supervisor: hand sequences for
// bring-up latency, then a vector table for the multi-cycle scenarios.
module tb_aurora_mmcm_supervisor;

  localparam int S_WSRC = 0;
  localparam int S_HOLD = 1;
  localparam int S_WLK  = 2;
  localparam int S_STB  = 3;
  localparam int S_RUN  = 4;
  localparam int S_FLT  = 5;

  logic clk;
  logic rst_n;

  aurora_mmcm_supervisor_if #(
    .N_CLK (2),
    .LOSS_W(16)
  ) bus ();

  aurora_mmcm_supervisor #(
    .N_CLK        (2),
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(16),
    .MAX_RETRIES  (3),
    .LOSS_W       (16)
  ) dut (
    .INIT_CLK    (clk),
    .INIT_RESET_N(rst_n),
    .sup         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rstn;
    logic [1:0] clk_lk;
    logic       mm;
    logic       rt;
    logic       cc;
    int         st;
    logic       clr;
    logic       rst;
    logic       rdy;
    logic       flt;
    int         rc;
    int         ll;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(
    input string nm,
    input int st, input int clr, input int rst,
    input int rdy, input int flt, input int rc, input int ll
  );
    chk({nm, "_state"}, int'(bus.STATE), st);
    chk({nm, "_clr"}, int'(bus.TX_CLK_CLR), clr);
    chk({nm, "_rst"}, int'(bus.MMCM_RESET), rst);
    chk({nm, "_ready"}, int'(bus.CLK_READY), rdy);
    chk({nm, "_fault"}, int'(bus.FAULT), flt);
    chk({nm, "_retries"}, int'(bus.RETRY_COUNT), rc);
    chk({nm, "_losses"}, int'(bus.LOCK_LOSS_COUNT), ll);
  endtask

  task automatic v(
    input int cyc, input logic rstn, input logic [1:0] ck,
    input logic mm, input logic rt, input logic cc,
    input int st, input logic clr, input logic rst,
    input logic rdy, input logic flt, input int rc, input int ll
  );
    vecs.push_back(vec_t'{cyc, rstn, ck, mm, rt, cc,
                          st, clr, rst, rdy, flt, rc, ll});
  endtask

  initial begin
    int n;

    // Starts in RUN with lock held; each row: hold inputs cyc cycles.
    // lock loss, 5 cycles low, relock
    v(3, 1, 3, 0, 0, 0, S_HOLD, 0, 1, 0, 0, 0, 1);
    v(2, 1, 3, 0, 0, 0, S_HOLD, 0, 1, 0, 0, 0, 1);
    v(2, 1, 3, 1, 0, 0, S_WLK,  0, 0, 0, 0, 0, 1);
    v(1, 1, 3, 1, 0, 0, S_STB,  0, 0, 0, 0, 0, 1);
    v(15, 1, 3, 1, 0, 0, S_RUN, 0, 0, 0, 0, 0, 1);
    v(1, 1, 3, 1, 0, 0, S_RUN,  0, 0, 1, 0, 0, 1);
    // lock glitch at stable count 10
    v(1, 1, 3, 0, 0, 0, S_RUN,  0, 0, 1, 0, 0, 1);
    v(2, 1, 3, 1, 0, 0, S_HOLD, 0, 1, 0, 0, 0, 2);
    v(4, 1, 3, 1, 0, 0, S_WLK,  0, 0, 0, 0, 0, 2);
    v(1, 1, 3, 1, 0, 0, S_STB,  0, 0, 0, 0, 0, 2);
    v(8, 1, 3, 1, 0, 0, S_STB,  0, 0, 0, 0, 0, 2);
    v(1, 1, 3, 0, 0, 0, S_STB,  0, 0, 0, 0, 0, 2);
    v(2, 1, 3, 1, 0, 0, S_HOLD, 0, 1, 0, 0, 1, 2);
    v(5, 1, 3, 1, 0, 0, S_STB,  0, 0, 0, 0, 1, 2);
    v(16, 1, 3, 1, 0, 0, S_RUN, 0, 0, 1, 0, 1, 2);
    // clear counts, then lock never returns: 3 timeouts -> FAULT
    v(1, 1, 3, 1, 0, 1, S_RUN,  0, 0, 1, 0, 0, 0);
    v(3, 1, 3, 0, 0, 0, S_HOLD, 0, 1, 0, 0, 0, 1);
    v(4, 1, 3, 0, 0, 0, S_WLK,  0, 0, 0, 0, 0, 1);
    v(99, 1, 3, 0, 0, 0, S_WLK, 0, 0, 0, 0, 0, 1);
    v(1, 1, 3, 0, 0, 0, S_HOLD, 0, 1, 0, 0, 1, 1);
    v(4, 1, 3, 0, 0, 0, S_WLK,  0, 0, 0, 0, 1, 1);
    v(100, 1, 3, 0, 0, 0, S_HOLD, 0, 1, 0, 0, 2, 1);
    v(104, 1, 3, 0, 0, 0, S_FLT, 1, 1, 0, 1, 3, 1);
    v(20, 1, 3, 0, 0, 0, S_FLT, 1, 1, 0, 1, 3, 1);
    v(5, 1, 1, 0, 0, 0, S_FLT,  1, 1, 0, 1, 3, 1);
    v(3, 1, 3, 0, 0, 0, S_FLT,  1, 1, 0, 1, 3, 1);
    v(1, 1, 3, 0, 1, 0, S_WSRC, 1, 1, 0, 0, 3, 1);
    v(1, 1, 3, 0, 0, 0, S_HOLD, 0, 1, 0, 0, 3, 1);
    v(1, 1, 3, 0, 1, 0, S_HOLD, 0, 1, 0, 0, 3, 1);
    v(3, 1, 3, 0, 0, 0, S_WLK,  0, 0, 0, 0, 3, 1);
    v(3, 1, 3, 1, 0, 0, S_STB,  0, 0, 0, 0, 3, 1);
    v(16, 1, 3, 1, 0, 0, S_RUN, 0, 0, 1, 0, 3, 1);
    // source and lock lost together: source wins, loss still counted
    v(3, 1, 1, 0, 0, 0, S_WSRC, 1, 1, 0, 0, 3, 2);
    v(3, 1, 3, 1, 0, 0, S_HOLD, 0, 1, 0, 0, 3, 2);
    v(21, 1, 3, 1, 0, 0, S_RUN, 0, 0, 1, 0, 3, 2);
    // one-cycle reset while in RUN
    v(1, 0, 3, 1, 0, 0, S_WSRC, 1, 1, 0, 0, 0, 0);
    v(3, 1, 3, 1, 0, 0, S_HOLD, 0, 1, 0, 0, 0, 0);
    v(21, 1, 3, 1, 0, 0, S_RUN, 0, 0, 1, 0, 0, 0);
    // clear coincident with a lock-loss increment
    v(2, 1, 3, 0, 0, 0, S_RUN,  0, 0, 1, 0, 0, 0);
    v(1, 1, 3, 0, 0, 1, S_HOLD, 0, 1, 0, 0, 0, 0);
    v(4, 1, 3, 0, 0, 0, S_WLK,  0, 0, 0, 0, 0, 0);

    rst_n            = 1'b0;
    bus.CLK_LOCKED   = 2'b01;
    bus.MMCM_LOCKED  = 1'b0;
    bus.RETRY_REQ    = 1'b0;
    bus.CLEAR_COUNTS = 1'b0;
    repeat (3) tick();
    chk_all("reset", S_WSRC, 1, 1, 0, 0, 0, 0);

    rst_n = 1'b1;
    repeat (50) tick();
    chk_all("t1_partial_src", S_WSRC, 1, 1, 0, 0, 0, 0);

    bus.CLK_LOCKED = 2'b11;
    n = 0;
    while (bus.TX_CLK_CLR && n < 20) begin
      tick();
      n++;
    end
    chk("t1_clr_latency", n, 3);
    chk("t1_state_hold", int'(bus.STATE), S_HOLD);
    chk("t1_rst_held", int'(bus.MMCM_RESET), 1);

    n = 0;
    while (bus.MMCM_RESET && n < 20) begin
      tick();
      n++;
    end
    chk("t1_rst_width", n, 4);
    chk("t1_state_wlk", int'(bus.STATE), S_WLK);

    repeat (10) tick();
    bus.MMCM_LOCKED = 1'b1;
    n = 0;
    while (!bus.CLK_READY && n < 40) begin
      tick();
      n++;
    end
    chk("t2_ready_latency", n, 19);
    chk_all("t2_run", S_RUN, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      rst_n            = vecs[i].rstn;
      bus.CLK_LOCKED   = vecs[i].clk_lk;
      bus.MMCM_LOCKED  = vecs[i].mm;
      bus.RETRY_REQ    = vecs[i].rt;
      bus.CLEAR_COUNTS = vecs[i].cc;
      repeat (vecs[i].cyc) tick();
      chk_all($sformatf("vec%0d", i),
              vecs[i].st, int'(vecs[i].clr), int'(vecs[i].rst),
              int'(vecs[i].rdy), int'(vecs[i].flt),
              vecs[i].rc, vecs[i].ll);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
